// File: rtl/cam_ctrl_pkg.sv
// Shared definitions for the camera line scheduler: FSM encoding and status-pulse bit indices.
package cam_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StWaitLine,
        StLine,
        StReq
    } state_e;

    localparam int unsigned PulseFrameDone = 0;
    localparam int unsigned PulseLineErr   = 1;
    localparam int unsigned PulseLineDrop  = 2;
    localparam int unsigned PulseFrameErr  = 3;
    localparam int unsigned NumPulses      = 4;

    localparam int unsigned ByteCntW = 12;

endpackage

// File: rtl/detect_falling_edge.sv
// Registered falling-edge detector; fall_o is high in the cycle the input is first seen low.
module detect_falling_edge (
    input  logic clk_i,
    input  logic rst_n,
    input  logic sig_i,
    output logic fall_o
);

    logic sig_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign fall_o = sig_q & ~sig_i;

endmodule

// File: rtl/cam_line_scheduler.sv
// Per-line admission and transmit handshake between the camera capture stage and the packetiser.
// Define FRAME_STATS_EN to add per-frame saturating drop/error counters (drop_cnt, err_cnt).
module cam_line_scheduler
    import cam_ctrl_pkg::*;
#(
    parameter int unsigned H_PIXELS   = 640,
    parameter int unsigned V_LINES    = 480,
    parameter int unsigned COLOR_MODE = 1,
    parameter int unsigned FIFO_AW    = 12
) (
    input  logic             PCLK_cam,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             VSYNC_cam,
    input  logic             HREF_cam,
    input  logic             pixel_valid,
    input  logic [FIFO_AW:0] fifo_free,
    output logic             out_ready,
    output logic             line_req,
    input  logic             line_ack,
    output logic [15:0]      line_num,
    output logic [15:0]      frame_num,
    output logic             frame_done,
    output logic             line_err,
    output logic             line_drop,
    output logic             frame_err
`ifdef FRAME_STATS_EN
    ,
    output logic [15:0]      drop_cnt,
    output logic [15:0]      err_cnt
`endif
);

    localparam int unsigned LINE_BYTES = H_PIXELS * COLOR_MODE;
    localparam logic [ByteCntW-1:0] LineBytesCnt = ByteCntW'(LINE_BYTES);

    state_e                state_q, state_d;
    logic [15:0]           line_num_q, line_num_d;
    logic [15:0]           frame_num_q, frame_num_d;
    logic [ByteCntW-1:0]   byte_cnt_q, byte_cnt_d;
    logic                  granted_q, granted_d;
    logic                  frame_end_q, frame_end_d;
    logic                  line_req_q, line_req_d;
    logic                  out_ready_q, out_ready_d;
    logic [NumPulses-1:0]  pulse_q, pulse_d;
    logic                  href_q, vsync_q;
    logic                  href_rise, href_fall, vsync_rise, vsync_fall;
    logic                  start_line, close_line, premature;

    detect_falling_edge u_vsync_fall (
        .clk_i  (PCLK_cam),
        .rst_n  (rst_n),
        .sig_i  (VSYNC_cam),
        .fall_o (vsync_fall)
    );

    assign href_rise  = HREF_cam & ~href_q;
    assign href_fall  = ~HREF_cam & href_q;
    assign vsync_rise = VSYNC_cam & ~vsync_q;

    always_comb begin
        state_d     = state_q;
        line_num_d  = line_num_q;
        frame_num_d = frame_num_q;
        byte_cnt_d  = byte_cnt_q;
        granted_d   = granted_q;
        frame_end_d = frame_end_q;
        line_req_d  = line_req_q;
        pulse_d     = '0;
        start_line  = 1'b0;
        close_line  = 1'b0;
        premature   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StArmed;
            end
            StArmed: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (vsync_fall) begin
                    state_d    = StWaitLine;
                    line_num_d = '0;
                end
            end
            StWaitLine: begin
                if (vsync_rise) premature = 1'b1;
                else if (href_rise) start_line = 1'b1;
            end
            StLine: begin
                if (vsync_rise) begin
                    premature = 1'b1;
                end else if (href_fall) begin
                    close_line = 1'b1;
                    state_d    = StWaitLine;
                    // Dropped lines already reported line_drop; they never raise line_err.
                    if (granted_q && byte_cnt_q == LineBytesCnt) begin
                        state_d    = StReq;
                        line_req_d = 1'b1;
                    end else if (granted_q) begin
                        pulse_d[PulseLineErr] = 1'b1;
                    end
                end else if (pixel_valid && granted_q) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end
            StReq: begin
                if (line_ack) begin
                    line_req_d  = 1'b0;
                    frame_end_d = 1'b0;
                    if (frame_end_q) begin
                        state_d = enable ? StArmed : StIdle;
                    end else begin
                        state_d    = StWaitLine;
                        start_line = href_rise;
                    end
                end else if (href_rise && !frame_end_q) begin
                    // Overrun: the new line is abandoned but still counts toward the frame.
                    line_req_d             = 1'b0;
                    pulse_d[PulseLineDrop] = 1'b1;
                    state_d                = StWaitLine;
                    close_line             = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (premature) begin
            pulse_d[PulseFrameErr] = 1'b1;
            line_num_d             = '0;
            state_d                = StArmed;
        end

        if (start_line) begin
            state_d    = StLine;
            byte_cnt_d = '0;
            granted_d  = 32'(fifo_free) >= LINE_BYTES;
            if (!granted_d) pulse_d[PulseLineDrop] = 1'b1;
        end

        if (close_line) begin
            line_num_d = line_num_q + 16'd1;
            if (32'(line_num_q) + 32'd1 == V_LINES) begin
                pulse_d[PulseFrameDone] = 1'b1;
                frame_num_d             = frame_num_q + 16'd1;
                line_num_d              = '0;
                // The last line may still need its transmit handshake before re-arming.
                if (state_d == StReq) frame_end_d = 1'b1;
                else state_d = enable ? StArmed : StIdle;
            end
        end

        out_ready_d = (state_d == StArmed) || (state_d == StLine && granted_d);
    end

    always_ff @(posedge PCLK_cam or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            line_num_q  <= '0;
            frame_num_q <= '0;
            byte_cnt_q  <= '0;
            granted_q   <= 1'b0;
            frame_end_q <= 1'b0;
            line_req_q  <= 1'b0;
            out_ready_q <= 1'b0;
            pulse_q     <= '0;
            href_q      <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_num_q  <= line_num_d;
            frame_num_q <= frame_num_d;
            byte_cnt_q  <= byte_cnt_d;
            granted_q   <= granted_d;
            frame_end_q <= frame_end_d;
            line_req_q  <= line_req_d;
            out_ready_q <= out_ready_d;
            pulse_q     <= pulse_d;
            href_q      <= HREF_cam;
            vsync_q     <= VSYNC_cam;
        end
    end

    assign out_ready  = out_ready_q;
    assign line_req   = line_req_q;
    assign line_num   = line_num_q;
    assign frame_num  = frame_num_q;
    assign frame_done = pulse_q[PulseFrameDone];
    assign line_err   = pulse_q[PulseLineErr];
    assign line_drop  = pulse_q[PulseLineDrop];
    assign frame_err  = pulse_q[PulseFrameErr];

`ifdef FRAME_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d, err_cnt_q, err_cnt_d;

    // Totals stay visible during the frame_done pulse and restart the cycle after.
    always_comb begin
        drop_cnt_d = pulse_q[PulseFrameDone] ? '0 : drop_cnt_q;
        err_cnt_d  = pulse_q[PulseFrameDone] ? '0 : err_cnt_q;
        if (pulse_d[PulseLineDrop] && drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + 16'd1;
        if (pulse_d[PulseLineErr] && err_cnt_d != '1) err_cnt_d = err_cnt_d + 16'd1;
    end

    always_ff @(posedge PCLK_cam or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: doc/cam_line_scheduler.md
CAM_LINE_SCHEDULER -- requirements
Module: cam_line_scheduler

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640: active pixels per line.
REQ-002 SHALL have parameter V_LINES, default 480: active lines per frame.
REQ-003 SHALL have parameter COLOR_MODE, default 1: 1 = grayscale, 1 byte/pixel; 2 = RGB565, 2 bytes/pixel.
REQ-004 SHALL have parameter FIFO_AW, default 12: downstream FIFO address width.
REQ-005 SHALL have port PCLK_cam  in  1: clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-007 SHALL have port enable  in  1: capture enable, level.
REQ-008 SHALL have ports VSYNC_cam and HREF_cam  in  1 each: camera syncs.
REQ-009 SHALL have port pixel_valid  in  1: byte strobe from the capture stage.
REQ-010 SHALL have port fifo_free  in  FIFO_AW+1: free bytes in the downstream FIFO.
REQ-011 SHALL have port out_ready  out  1: grant to the capture stage.
REQ-012 SHALL have ports line_req  out  1 and line_ack  in  1: per-line transmit handshake to the UDP packetiser.
REQ-013 SHALL have ports line_num and frame_num  out  16 each: current line index and frame index.
REQ-014 SHALL have ports frame_done, line_err, line_drop and frame_err  out  1 each: single-cycle status pulses.

Function
REQ-015 SHALL define LINE_BYTES = H_PIXELS*COLOR_MODE as an elaboration-time constant.
REQ-016 SHALL implement FSM states IDLE, ARMED, WAIT_LINE, LINE, REQ.
- IDLE -> ARMED: enable=1.
- ARMED -> WAIT_LINE: VSYNC falling edge.
- WAIT_LINE -> LINE: HREF rising edge.
- LINE -> REQ or WAIT_LINE: HREF falling edge.
- REQ -> WAIT_LINE: line_ack.
REQ-017 SHALL, at each HREF rise in WAIT_LINE, grant the line if fifo_free >= LINE_BYTES; otherwise it SHALL drop the line and pulse line_drop.
- A granted line holds out_ready=1 until the HREF fall.
- A dropped line holds out_ready=0 for the whole line.
REQ-018 SHALL assert out_ready in ARMED, so the capture stage can arm on the VSYNC fall.
REQ-019 SHALL count pixel_valid strobes in a 12-bit byte counter during LINE, cleared at each HREF rise.
REQ-020 SHALL, at the HREF fall of a granted line with count == LINE_BYTES, enter REQ and assert line_req until the cycle line_ack is sampled high.
REQ-021 SHALL, at an HREF fall with count != LINE_BYTES, pulse line_err, skip REQ and return to WAIT_LINE.
REQ-022 SHALL increment line_num after every line (granted, dropped or errored).
REQ-023 SHALL, when line_num reaches V_LINES:
- pulse frame_done;
- increment frame_num (wrapping 0xFFFF->0);
- clear line_num;
- return to ARMED, or to IDLE if enable=0.
REQ-024 SHALL treat a VSYNC rise in LINE or WAIT_LINE before V_LINES lines as premature: pulse frame_err, clear line_num, go to ARMED, and leave frame_num unchanged.
REQ-025 SHALL, on an HREF rise while in REQ (overrun), pulse line_drop, deassert line_req, go to WAIT_LINE and ignore that line.
REQ-026 SHALL give line_ack precedence when line_ack and the HREF rise coincide: the ack completes, and the new line is evaluated per REQ-017 in the same cycle.
REQ-027 SHALL ignore line_ack outside REQ.
REQ-028 SHALL, when enable falls, finish the current frame; enable=0 in ARMED SHALL return to IDLE.
REQ-029 SHALL register all outputs, with 1-cycle latency from the triggering edge detection.

Reset
REQ-030 SHALL, while rst_n=0, force state IDLE and all outputs, counters and edge-detect registers to 0.
REQ-031 SHALL, on reset release mid-frame, wait in ARMED for the next VSYNC fall with no status pulses.

Configuration
REQ-032 SHALL, when FRAME_STATS_EN is defined, add outputs drop_cnt and err_cnt (16 bits each, saturating, cleared at each frame_done).
- drop_cnt counts line_drop pulses; err_cnt counts line_err pulses.
REQ-033 SHALL, without FRAME_STATS_EN, omit those ports and counters entirely.

Structure
REQ-034 SHALL place the FSM state encoding and the status-pulse bit indices in the shared package cam_ctrl_pkg.
REQ-035 SHALL instantiate the existing detect_falling_edge sub-module for VSYNC; HREF rise/fall detection SHALL be local registers.

Verification
REQ-036 SHALL cover a nominal frame: H_PIXELS=8, V_LINES=4, COLOR_MODE=1, fifo_free=4095, line_ack 2 cycles after each line_req -> 4 line_req, frame_done once, frame_num=1, no errors.
REQ-037 SHALL cover a short line: 7 pixel_valid strobes on line 2 -> line_err on line 2, 3 line_req, frame_done once.
REQ-038 SHALL cover a full FIFO: fifo_free=7 at line 1 HREF rise -> line_drop, out_ready=0 during line 1, line_num still advances.
REQ-039 SHALL cover an overrun: line_ack withheld across the next HREF rise -> line_drop, line_req low, the following line is normal.
REQ-040 SHALL cover a premature VSYNC: VSYNC rise after 2 lines -> frame_err, line_num=0, frame_num unchanged, state ARMED.
REQ-041 SHALL cover reset mid-line: rst_n low for 3 cycles during LINE -> all outputs 0, and the next activity follows the next VSYNC fall.
